// File: rtl/uart_pkg.sv
// Shared UART definitions: default payload width and the stored receive entry layout.
package uart_pkg;

  localparam int UART_PAYLOAD_BITS = 8;

  typedef struct packed {
    logic                         brk;
    logic [UART_PAYLOAD_BITS-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO behind the UART receiver, with sticky overflow and a fill-level interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int PW       = AW + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_break,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_break,
  output logic [PW-1:0]        level,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  input  logic                 clear_overflow,
  input  logic                 flush,
  output logic                 irq_level
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] THR_L    = PW'(THRESHOLD);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               pop, push, drop;
  logic [DATA_BITS:0] head_raw;
  logic [DATA_BITS-1:0] head_data;
  logic               head_brk;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign out_valid = ~empty;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign irq_level = (level_q >= THR_L);

  // A flush swallows both a same-cycle byte and a same-cycle pop.
  assign pop  = out_valid & out_ready & ~flush;
  assign push = in_valid & (~full | pop) & ~flush;
  assign drop = in_valid & full & ~pop & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + PTR_ONE;
      else if (pop && !push) level_d = level_q - PTR_ONE;
    end
    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = drop | (ovf_q & ~clear_overflow);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({in_break, in_data}),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head_raw)
  );

  if (DATA_BITS == UART_PAYLOAD_BITS) begin : g_pkg_entry
    uart_rx_entry_t head_s;
    assign head_s    = head_raw;
    assign head_data = head_s.data;
    assign head_brk  = head_s.brk;
  end else begin : g_raw_entry
    assign head_data = head_raw[DATA_BITS-1:0];
    assign head_brk  = head_raw[DATA_BITS];
  end

  // Storage is uninitialised after reset, so the head is masked while empty.
  assign out_data  = empty ? '0 : head_data;
  assign out_break = empty ? 1'b0 : head_brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, overflow, break, threshold, flush, async reset, wrap.
module tb_uart_rx_fifo;

  logic       clk;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_break;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_break;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clear_overflow;
  logic       flush;
  logic       irq_level;

  int n_total = 0;
  int n_bad   = 0;

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(16), .THRESHOLD(8)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_break       (in_break),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_break      (out_break),
    .level          (level),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .flush          (flush),
    .irq_level      (irq_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic brk, input logic [7:0] d);
    in_valid = 1'b1;
    in_break = brk;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_break = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_level"},  32'(level), 32'd0);
    chk({tag, "_empty"},  32'(empty), 32'd1);
    chk({tag, "_full"},   32'(full), 32'd0);
    chk({tag, "_valid"},  32'(out_valid), 32'd0);
    chk({tag, "_ovf"},    32'(overflow), 32'd0);
    chk({tag, "_irq"},    32'(irq_level), 32'd0);
    chk({tag, "_data"},   32'(out_data), 32'd0);
    chk({tag, "_brk"},    32'(out_break), 32'd0);
  endtask

  logic [7:0] exp_q [$];

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_break = 1'b0;
    out_ready = 1'b0; clear_overflow = 1'b0; flush = 1'b0;
    tick(); tick();
    check_reset_state("rst");
    resetn = 1'b1;
    tick();

    // Basic ordering and first-word latency.
    push_byte(1'b0, 8'h41);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", 32'(out_data), 32'h41);
    push_byte(1'b0, 8'h42);
    push_byte(1'b0, 8'h43);
    chk("three_level", 32'(level), 32'd3);
    chk("three_head", 32'(out_data), 32'h41);
    for (int i = 0; i < 3; i++) begin
      chk("order_data", 32'(out_data), 32'(8'h41 + i));
      pop_one();
    end
    chk("order_empty", 32'(empty), 32'd1);

    // Fill, drop on overflow, then push-while-popping when full.
    for (int i = 0; i < 16; i++) push_byte(1'b0, 8'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    push_byte(1'b0, 8'hAA);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_level", 32'(level), 32'd16);
    chk("drop_head", 32'(out_data), 32'h00);
    out_ready = 1'b1;
    push_byte(1'b0, 8'hBB);
    out_ready = 1'b0;
    chk("pushpop_level", 32'(level), 32'd16);
    chk("pushpop_full", 32'(full), 32'd1);
    clear_overflow = 1'b1;
    push_byte(1'b0, 8'hCC);
    clear_overflow = 1'b0;
    chk("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_vs_drop_level", 32'(level), 32'd16);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hBB);
    while (exp_q.size() > 0) begin
      chk("drain_data", 32'(out_data), 32'(exp_q.pop_front()));
      pop_one();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Break entries are stored as given.
    push_byte(1'b1, 8'h00);
    chk("brk_flag", 32'(out_break), 32'd1);
    chk("brk_data", 32'(out_data), 32'h00);
    push_byte(1'b0, 8'h55);
    pop_one();
    chk("after_brk_flag", 32'(out_break), 32'd0);
    chk("after_brk_data", 32'(out_data), 32'h55);
    pop_one();
    chk("brk_empty", 32'(empty), 32'd1);

    // Threshold interrupt.
    for (int i = 0; i < 7; i++) push_byte(1'b0, 8'(8'h10 + i));
    chk("irq_at7", 32'(irq_level), 32'd0);
    push_byte(1'b0, 8'h17);
    chk("irq_at8", 32'(irq_level), 32'd1);
    chk("irq_level8", 32'(level), 32'd8);
    pop_one();
    chk("irq_after_pop", 32'(irq_level), 32'd0);
    pop_one();
    pop_one();
    chk("pre_flush_level", 32'(level), 32'd5);

    // Flush with a colliding byte and pop.
    flush = 1'b1;
    out_ready = 1'b1;
    push_byte(1'b0, 8'h99);
    flush = 1'b0;
    out_ready = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf_kept", 32'(overflow), 32'd1);
    push_byte(1'b0, 8'h5A);
    chk("post_flush_head", 32'(out_data), 32'h5A);
    chk("post_flush_level", 32'(level), 32'd1);
    pop_one();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clear_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 9; i++) push_byte(1'b0, 8'(8'h60 + i));
    chk("pre_rst_level", 32'(level), 32'd9);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_state("async_rst");
    tick();
    resetn = 1'b1;
    tick();

    // 40 push/pop pairs: 2.5 pointer wraps.
    for (int k = 0; k < 40; k++) begin
      push_byte(1'b0, 8'(8'h80 + k));
      chk("wrap_data", 32'(out_data), 32'(8'h80 + k));
      pop_one();
    end
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures each single-cycle received-byte pulse and its break indication into a circular FIFO. Presents the buffered bytes to the bus/CPU side over a valid/ready interface, first-word-fall-through. The receiver cannot be back-pressured, so the block reports overflow and a fill-level threshold interrupt.

Parameters:
- DATA_BITS, 8, payload width; must match the receiver's PAYLOAD_BITS.
- DEPTH, 16, number of entries; power of two, at least 2.
- THRESHOLD, 8, fill level at or above which irq_level asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- in_valid  in  1  single-cycle pulse: received byte available
- in_data  in  DATA_BITS  received byte, sampled when in_valid=1
- in_break  in  1  break condition, sampled when in_valid=1
- out_valid  out  1  FIFO non-empty; head entry presented
- out_ready  in  1  consumer accepts head entry
- out_data  out  DATA_BITS  head entry data
- out_break  out  1  head entry break flag
- level  out  $clog2(DEPTH)+1  current number of stored entries
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- overflow  out  1  sticky: a byte was dropped
- clear_overflow  in  1  single-cycle clear of overflow
- flush  in  1  synchronous discard of all entries
- irq_level  out  1  level >= THRESHOLD

Behaviour:
- Interface (already decided): one clock, clk. Reset resetn is asynchronous and active-low.
- Reset values:
  - level=0, empty=1, full=0.
  - out_valid=0, overflow=0, irq_level=0.
  - out_data and out_break read 0 (storage head is don't-care but masked to 0 while empty).
  - Pointers reset to 0.
- Storage:
  - Each entry is {break, data}, DATA_BITS+1 bits wide.
  - Write and read pointers are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - full when the pointers differ only in the MSB; empty when they are equal.
- pop: out_valid && out_ready. Advances the read pointer at the clock edge.
- push: in_valid && (!full || pop). Writes the entry at the write pointer and advances it.
  - A push while full is accepted only when a pop happens in the same cycle.
- Latency: a push at edge N makes out_valid=1 and the head data visible after edge N. No combinational path from in_* to out_*.
- FWFT: out_data and out_break are driven from the head entry whenever out_valid=1. They stay stable until the pop.
- Level:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - level is registered. full, empty and irq_level are derived from the registered level or pointers.
- Overflow:
  - in_valid && full && !pop drops the byte; storage is unchanged and overflow sets.
  - overflow holds until clear_overflow.
  - If clear_overflow and a new drop occur in the same cycle, set wins and overflow stays 1.
- Break: stored like data. in_data on break is normally 0 but is stored as given. A break never triggers any special clearing.
- Flush:
  - Next edge: both pointers go to 0 and level to 0.
  - An in_valid in the same cycle is discarded and does not set overflow.
  - A pop in the same cycle is ignored.
  - flush does not clear overflow.
- Pointer wrap: after DEPTH pushes and DEPTH pops, behaviour is identical to the initial state. Checked across at least 2 full wraps.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Stored contents are lost.

Decomposition:
- Package uart_pkg:
  - UART_PAYLOAD_BITS=8 default constant.
  - typedef struct packed {logic brk; logic [UART_PAYLOAD_BITS-1:0] data;} uart_rx_entry_t, used when DATA_BITS equals the default.
- Sub-module uart_fifo_mem:
  - DEPTH x (DATA_BITS+1) storage.
  - One synchronous write port and one asynchronous read port; no reset on the array.
- The top level holds pointers, level, flags and overflow logic.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate cycles with out_ready=0 -> level=3, out_data=0x41, out_valid=1 one cycle after the first push. Then out_ready=1 for 3 cycles -> reads 0x41, 0x42, 0x43 in order, then empty=1.
- Fill 16 entries 0x00..0x0F, then push 0xAA with out_ready=0 -> full=1, overflow=1, level=16, and 0xAA is never read. Next, push 0xBB while popping -> accepted, level stays 16, and 0xBB is read last after 0x01..0x0F.
- Push in_break=1 with in_data=0x00 -> out_break=1, out_data=0x00 at the head. A following normal byte 0x55 -> out_break=0.
- Push 7 entries -> irq_level=0. 8th push -> irq_level=1. One pop -> irq_level=0.
- flush asserted together with in_valid=1 (0x99) while level=5 -> level=0, empty=1, overflow unchanged, 0x99 absent. clear_overflow pulsed in the same cycle as an overflowing push -> overflow remains 1.
- Assert resetn=0 asynchronously mid-stream with level=9 -> outputs return to reset values without waiting for a clk edge. After release, 40 push/pop pairs (2.5 wraps) read back in order with no loss.
